// File: rtl/async_fifo_pkg.sv
// Shared types and pointer helpers for the async FIFO controllers.
// Pointers carry one extra MSB so that full and empty can be told apart.
package async_fifo_pkg;

  localparam int ADDR_W   = 3;
  localparam int BYTE_W   = 8;
  localparam int DATA_W   = 2 * BYTE_W;
  localparam int AF_LEVEL = 6;

  typedef logic [ADDR_W:0] ptr_t;

  typedef enum logic {LO, HI} wr_state_e;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock.
// Shared by the write-side and read-side controllers.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side FIFO controller: packs bytes into 16-bit RAM words and publishes a Gray write pointer.
// Define WR_CTRL_ALMOST_FULL_EN to build the registered almost_full flag; otherwise it is tied low.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
(
  input  logic              wclk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] din,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic [ADDR_W:0]   wr_count,
  output logic              almost_full
);

  wr_state_e         state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  ptr_t              wbin_q, wbin_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, word_d;
  ptr_t              wgray_q;
  logic              full_q, full_d;
  ptr_t              count_q, count_d;
  ptr_t              rq2, rbin;
  logic              accept, issue;

  sync_2ff #(.W(ADDR_W + 1)) u_rd_sync (
    .clk (wclk),
    .rst (rst),
    .d_i (rd_ptr_gray),
    .q_o (rq2)
  );

  assign s_ready = !full_q && !rst;
  assign accept  = s_valid && s_ready;
  assign rbin    = gray2bin(rq2);

  // Byte packer: the first byte of a pair lands in the low half of the word.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    issue   = 1'b0;
    word_d  = din_q;
    if (accept) begin
      if (state_q == LO) begin
        if (s_last) begin
          issue  = 1'b1;
          word_d = {{BYTE_W{1'b0}}, s_data};
        end else begin
          hold_d  = s_data;
          state_d = HI;
        end
      end else begin
        issue   = 1'b1;
        word_d  = {s_data, hold_q};
        state_d = LO;
      end
    end
  end

  // Full compares the post-edge pointer so the filling write raises full on the same edge.
  always_comb begin
    wbin_d  = wbin_q + ptr_t'(issue);
    full_d  = bin2gray(wbin_d) == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
    count_d = wbin_d - rbin;
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q <= LO;
      hold_q  <= '0;
      wbin_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wbin_q  <= wbin_d;
      we_q    <= issue;
      if (issue) begin
        addr_q <= wbin_q[ADDR_W-1:0];
        din_q  <= word_d;
      end
      wgray_q <= bin2gray(wbin_q);
      full_q  <= full_d;
      count_q <= count_d;
    end
  end

`ifdef WR_CTRL_ALMOST_FULL_EN
  logic af_q;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= count_d >= ptr_t'(AF_LEVEL);
    end
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

  assign we          = we_q;
  assign wr_addr     = addr_q;
  assign din         = din_q;
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign wr_count    = count_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed self-checking bench for the write-side FIFO controller.
module tb_async_fifo_wr_ctrl;

  logic        wclk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic [3:0]  rd_ptr_gray;
  logic        we;
  logic [2:0]  wr_addr;
  logic [15:0] din;
  logic [3:0]  wr_ptr_gray;
  logic        full;
  logic [3:0]  wr_count;
  logic        almost_full;

  int checks = 0;
  int errors = 0;

  async_fifo_wr_ctrl dut (
    .wclk        (wclk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .rd_ptr_gray (rd_ptr_gray),
    .we          (we),
    .wr_addr     (wr_addr),
    .din         (din),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .wr_count    (wr_count),
    .almost_full (almost_full)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expectedAf(input int count);
`ifdef WR_CTRL_ALMOST_FULL_EN
    return count >= 6;
`else
    return (count < 0);
`endif
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int waited;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    waited  = 0;
    while (!s_ready && waited < 50) begin
      @(negedge wclk);
      waited++;
    end
    if (!s_ready) checkOutput("accept_timeout", 32'(waited), 32'd0);
    @(posedge wclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge wclk);
  endtask

  task automatic resetDut();
    @(negedge wclk);
    rst         = 1'b1;
    rd_ptr_gray = 4'd0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = 8'h00;
    @(negedge wclk);
    @(negedge wclk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_we"},     32'(we), 32'd0);
    checkOutput({tag, "_addr"},   32'(wr_addr), 32'd0);
    checkOutput({tag, "_din"},    32'(din), 32'd0);
    checkOutput({tag, "_wgray"},  32'(wr_ptr_gray), 32'd0);
    checkOutput({tag, "_full"},   32'(full), 32'd0);
    checkOutput({tag, "_count"},  32'(wr_count), 32'd0);
    checkOutput({tag, "_af"},     32'(almost_full), 32'd0);
    checkOutput({tag, "_sready"}, 32'(s_ready), 32'd0);
  endtask

  initial begin
    int lat;
    logic [3:0] grayTab [0:8];
    grayTab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Reset state
    rst = 1'b1;
    resetDut();
    checkResetState("reset");
    rst = 1'b0;
    @(negedge wclk);
    checkOutput("sready_after_reset", 32'(s_ready), 32'd1);

    // Test 1: two bytes pack into one word
    applyStimulus(8'h11, 1'b0);
    checkOutput("t1_no_write_on_first", 32'(we), 32'd0);
    applyStimulus(8'h22, 1'b0);
    checkOutput("t1_we", 32'(we), 32'd1);
    checkOutput("t1_din", 32'(din), 32'h2211);
    checkOutput("t1_addr", 32'(wr_addr), 32'd0);
    checkOutput("t1_wgray_not_yet", 32'(wr_ptr_gray), 32'd0);
    checkOutput("t1_count", 32'(wr_count), 32'd1);
    @(negedge wclk);
    checkOutput("t1_we_pulse", 32'(we), 32'd0);
    checkOutput("t1_wgray", 32'(wr_ptr_gray), 32'd1);
    checkOutput("t1_din_held", 32'(din), 32'h2211);

    // Test 2: single byte with s_last is padded and state stays LO
    applyStimulus(8'hAB, 1'b1);
    checkOutput("t2_we", 32'(we), 32'd1);
    checkOutput("t2_din", 32'(din), 32'h00AB);
    checkOutput("t2_addr", 32'(wr_addr), 32'd1);
    applyStimulus(8'hCD, 1'b0);
    checkOutput("t2_still_lo", 32'(we), 32'd0);
    applyStimulus(8'hEF, 1'b1);
    checkOutput("t2_din_pair", 32'(din), 32'hEFCD);
    checkOutput("t2_addr_pair", 32'(wr_addr), 32'd2);

    // Test 3: fill the RAM from empty
    rst = 1'b1;
    resetDut();
    rst = 1'b0;
    @(negedge wclk);
    for (int w = 0; w < 8; w++) begin
      applyStimulus(8'(2 * w), 1'b0);
      applyStimulus(8'(2 * w + 1), 1'b0);
      checkOutput($sformatf("t3_addr%0d", w), 32'(wr_addr), 32'(w));
      checkOutput($sformatf("t3_din%0d", w), 32'(din), {16'h0, 8'(2 * w + 1), 8'(2 * w)});
      checkOutput($sformatf("t3_count%0d", w), 32'(wr_count), 32'(w + 1));
      checkOutput($sformatf("t3_af%0d", w), 32'(almost_full), 32'(expectedAf(w + 1)));
      checkOutput($sformatf("t3_full%0d", w), 32'(full), 32'(w == 7));
    end
    @(negedge wclk);
    checkOutput("t3_sready", 32'(s_ready), 32'd0);
    checkOutput("t3_count", 32'(wr_count), 32'd8);
    checkOutput("t3_wgray", 32'(wr_ptr_gray), 32'(grayTab[8]));

    // Test 4: read pointer advances by one; full releases after the synchroniser
    rd_ptr_gray = 4'b0001;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge wclk);
      if (!full) begin
        lat = i;
        break;
      end
    end
    checkOutput("t4_full_latency_ok", 32'(lat >= 2 && lat <= 3), 32'd1);
    checkOutput("t4_count", 32'(wr_count), 32'd7);
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("t4_addr_wrap", 32'(wr_addr), 32'd0);
    checkOutput("t4_din", 32'(din), 32'hA55A);
    checkOutput("t4_full_again", 32'(full), 32'd1);
    checkOutput("t4_count_full", 32'(wr_count), 32'd8);
    @(negedge wclk);
    checkOutput("t4_wgray_msb", 32'(wr_ptr_gray), 32'b1101);

    // Test 5: reset while a byte is held discards it
    rst = 1'b1;
    resetDut();
    rst = 1'b0;
    @(negedge wclk);
    applyStimulus(8'h33, 1'b0);
    @(negedge wclk);
    rst = 1'b1;
    #1;
    checkResetState("t5_rst");
    @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
    applyStimulus(8'h44, 1'b0);
    checkOutput("t5_no_write", 32'(we), 32'd0);
    applyStimulus(8'h55, 1'b0);
    checkOutput("t5_we", 32'(we), 32'd1);
    checkOutput("t5_din", 32'(din), 32'h5544);
    checkOutput("t5_addr", 32'(wr_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
